// File: rtl/spi_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_pkg : FSM state encoding and word width shared with the master |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package spi_pkg;

  localparam int SPI_WORD_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } spi_state_e;

endpackage
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | byte_fifo : synchronous FIFO with registered read and full/empty    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module byte_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int c_AW = $clog2(DEPTH);
  localparam logic [c_AW:0] c_PTR_ONE = {{c_AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [c_AW:0]    wptr_q;
  logic [c_AW:0]    rptr_q;
  logic [WIDTH-1:0] rd_data_q;
  logic             w_push;
  logic             w_pop;

  // The extra MSB on each pointer separates the full case from empty.
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[c_AW] != rptr_q[c_AW]) &&
                   (wptr_q[c_AW-1:0] == rptr_q[c_AW-1:0]);
  assign w_push  = wr_en_i && !full_o;
  assign w_pop   = rd_en_i && !empty_o;

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wptr_q[c_AW-1:0]] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      rd_data_q <= '0;
    end else begin
      if (w_push) begin
        wptr_q <= wptr_q + c_PTR_ONE;
      end
      if (w_pop) begin
        rptr_q    <= rptr_q + c_PTR_ONE;
        rd_data_q <= mem_q[rptr_q[c_AW-1:0]];
      end
    end
  end

  assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sync_2ff : two-flop synchronizer for a single asynchronous bit      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/spi_subordinate.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_subordinate : oversampled SPI mode-0 slave with RX/TX FIFOs     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module spi_subordinate
  import spi_pkg::*;
#(
  parameter int                    FIFO_DEPTH = 16,
  parameter logic [SPI_WORD_W-1:0] FILL_BYTE  = 8'hFF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk_i,
  input  logic                  cs_n_i,
  input  logic                  mosi_i,
  output logic                  miso_o,
  output logic [SPI_WORD_W-1:0] rx_data_o,
  input  logic                  rx_read_en_i,
  output logic                  rx_empty_o,
  output logic                  rx_full_o,
  input  logic [SPI_WORD_W-1:0] tx_data_i,
  input  logic                  tx_write_en_i,
  output logic                  tx_empty_o,
  output logic                  tx_full_o,
  output logic                  busy_o,
  output logic                  byte_done_o,
  output logic                  rx_overrun_o,
  output logic                  tx_underrun_o,
  input  logic                  clear_status_i
);

  localparam int                 c_CNT_W = $clog2(SPI_WORD_W + 1);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(SPI_WORD_W - 1);
  localparam logic [c_CNT_W-1:0] c_WORD  = c_CNT_W'(SPI_WORD_W);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

  logic                  w_sclk_s, w_cs_n_s, w_mosi_s;
  logic                  sclk_hist_q, cs_hist_q;
  logic [1:0]            settle_q;
  logic                  w_cs_ok, w_cs_fall, w_cs_rise, w_sclk_rise, w_sclk_fall;
  spi_state_e            state_q, state_d;
  logic [c_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [SPI_WORD_W-2:0] rx_shift_q, rx_shift_d;
  logic [SPI_WORD_W-2:0] tx_shift_q, tx_shift_d;
  logic                  miso_q, miso_d, fill_sel_q, fill_sel_d;
  logic                  byte_done_q, byte_done_d;
  logic                  rx_overrun_q, rx_overrun_d, tx_underrun_q, tx_underrun_d;
  logic                  w_tx_pop, w_rx_push;
  logic [SPI_WORD_W-1:0] w_tx_rd_data, w_tx_byte, w_rx_byte;

  sync_2ff #(.RESET_VAL(1'b0)) u_sync_sclk (.clk, .rst_n, .d_i(sclk_i), .q_o(w_sclk_s));
  sync_2ff #(.RESET_VAL(1'b1)) u_sync_cs   (.clk, .rst_n, .d_i(cs_n_i), .q_o(w_cs_n_s));
  sync_2ff #(.RESET_VAL(1'b0)) u_sync_mosi (.clk, .rst_n, .d_i(mosi_i), .q_o(w_mosi_s));

  // CS edges are masked until the whole chain holds real pin samples, so a
  // CS_n that is already low when reset releases never looks like a new frame.
  assign w_cs_ok     = (settle_q == 2'd3);
  assign w_cs_fall   = w_cs_ok && cs_hist_q && !w_cs_n_s;
  assign w_cs_rise   = w_cs_ok && !cs_hist_q && w_cs_n_s;
  assign w_sclk_rise = w_sclk_s && !sclk_hist_q;
  assign w_sclk_fall = !w_sclk_s && sclk_hist_q;

  assign w_tx_byte = fill_sel_q ? FILL_BYTE : w_tx_rd_data;
  assign w_rx_byte = {rx_shift_q, w_mosi_s};

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    miso_d        = miso_q;
    fill_sel_d    = fill_sel_q;
    byte_done_d   = 1'b0;
    rx_overrun_d  = rx_overrun_q && !clear_status_i;
    tx_underrun_d = tx_underrun_q && !clear_status_i;
    w_tx_pop      = 1'b0;
    w_rx_push     = 1'b0;
    if (w_cs_rise) begin
      state_d   = IDLE;
      miso_d    = 1'b0;
      bit_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          miso_d    = 1'b0;
          bit_cnt_d = '0;
          if (w_cs_fall) begin
            w_tx_pop   = 1'b1;
            fill_sel_d = tx_empty_o;
            if (tx_empty_o) tx_underrun_d = 1'b1;
            state_d    = LOAD;
          end
        end
        LOAD: begin
          tx_shift_d = w_tx_byte[SPI_WORD_W-2:0];
          miso_d     = w_tx_byte[SPI_WORD_W-1];
          state_d    = SHIFT;
        end
        SHIFT: begin
          if (w_sclk_rise && bit_cnt_q < c_WORD) begin
            rx_shift_d = {rx_shift_q[SPI_WORD_W-3:0], w_mosi_s};
            bit_cnt_d  = bit_cnt_q + c_ONE;
            if (bit_cnt_q == c_LAST) begin
              w_rx_push   = 1'b1;
              byte_done_d = 1'b1;
              if (rx_full_o) rx_overrun_d = 1'b1;
              w_tx_pop    = 1'b1;
              fill_sel_d  = tx_empty_o;
              if (tx_empty_o) tx_underrun_d = 1'b1;
            end
          end else if (w_sclk_fall) begin
            if (bit_cnt_q == c_WORD) begin
              tx_shift_d = w_tx_byte[SPI_WORD_W-2:0];
              miso_d     = w_tx_byte[SPI_WORD_W-1];
              bit_cnt_d  = '0;
            end else if (bit_cnt_q != '0) begin
              miso_d     = tx_shift_q[SPI_WORD_W-2];
              tx_shift_d = {tx_shift_q[SPI_WORD_W-3:0], 1'b0};
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_hist_q   <= 1'b0;
      cs_hist_q     <= 1'b1;
      settle_q      <= '0;
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      rx_shift_q    <= '0;
      tx_shift_q    <= '0;
      miso_q        <= 1'b0;
      fill_sel_q    <= 1'b0;
      byte_done_q   <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      sclk_hist_q   <= w_sclk_s;
      cs_hist_q     <= w_cs_n_s;
      if (!w_cs_ok) settle_q <= settle_q + 2'd1;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      miso_q        <= miso_d;
      fill_sel_q    <= fill_sel_d;
      byte_done_q   <= byte_done_d;
      rx_overrun_q  <= rx_overrun_d;
      tx_underrun_q <= tx_underrun_d;
    end
  end

  byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(SPI_WORD_W)) u_rx_fifo (
    .clk, .rst_n,
    .wr_en_i(w_rx_push), .wr_data_i(w_rx_byte),
    .rd_en_i(rx_read_en_i), .rd_data_o(rx_data_o),
    .empty_o(rx_empty_o), .full_o(rx_full_o)
  );

  byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(SPI_WORD_W)) u_tx_fifo (
    .clk, .rst_n,
    .wr_en_i(tx_write_en_i), .wr_data_i(tx_data_i),
    .rd_en_i(w_tx_pop), .rd_data_o(w_tx_rd_data),
    .empty_o(tx_empty_o), .full_o(tx_full_o)
  );

  assign miso_o        = miso_q;
  assign busy_o        = !w_cs_n_s;
  assign byte_done_o   = byte_done_q;
  assign rx_overrun_o  = rx_overrun_q;
  assign tx_underrun_o = tx_underrun_q;

endmodule
`default_nettype wire

// File: doc/spi_subordinate.md
# spi_subordinate

- SPI subordinate (slave) endpoint: mode 0 (CPOL=0, CPHA=0), 8-bit, MSB-first.
- Oversamples the SPI pins with the system clock and moves bytes through internal RX and TX FIFOs.
- Sits on the peripheral-side FPGA and talks to the existing SPI master design.
- User logic writes response bytes into the TX FIFO and drains received bytes from the RX FIFO.

## Interface
- FIFO_DEPTH, 16, entries per FIFO; power of two, ≥ 2
- FILL_BYTE, 8'hFF, byte shifted out when the TX FIFO is empty at a byte boundary
- clk  in  1  system clock
- rst_n  in  1  reset: synchronous, active-low
- SCLK  in  1  SPI clock, asynchronous
- CS_n  in  1  chip select, active-low, asynchronous
- MOSI  in  1  SPI data in, asynchronous
- MISO  out  1  SPI data out; driven 0 while deselected
- rx_data  out  8  RX FIFO read data
- rx_read_en  in  1  pop RX FIFO; ignored when empty
- rx_empty / rx_full  out  1  RX FIFO status
- tx_data  in  8  TX FIFO write data
- tx_write_en  in  1  push TX FIFO; ignored when full
- tx_empty / tx_full  out  1  TX FIFO status
- busy  out  1  synchronized CS_n is low
- byte_done  out  1  one-cycle pulse per completed 8-bit byte
- rx_overrun  out  1  sticky: byte completed while RX FIFO full, byte dropped
- tx_underrun  out  1  sticky: FILL_BYTE was substituted for an empty TX FIFO
- clear_status  in  1  clears both sticky flags

## Operation
- SCLK, CS_n and MOSI each pass through a 2-flop synchronizer, then one history register; edges are detected on the synchronized values.
- FSM states:
  - IDLE: MISO=0, bit_cnt=0. On CS_n fall: pop the TX FIFO (or select FILL_BYTE and set tx_underrun), go to LOAD.
  - LOAD: one cycle. tx_shift ← popped byte; MISO ← bit 7; go to SHIFT.
  - SHIFT, SCLK rise: rx_shift ← {rx_shift[6:0], MOSI}; bit_cnt++.
  - SHIFT, rise that reaches bit_cnt=8: push the byte to the RX FIFO (if full, drop it and set rx_overrun); pulse byte_done; prefetch the next TX byte (pop, or FILL_BYTE + tx_underrun).
  - SHIFT, SCLK fall with bit_cnt=8: tx_shift ← prefetched byte; MISO ← its bit 7; bit_cnt=0.
  - SHIFT, SCLK fall with bit_cnt in 1..7: shift tx_shift left; MISO ← new bit 7.
- CS_n rise in any state → IDLE next cycle:
  - Partial RX byte discarded, no push, no byte_done.
  - A popped but unsent TX byte is lost.
  - MISO=0.
- Rise and fall edges are never detected in the same cycle; a CS_n edge takes priority over an SCLK edge.
- FIFOs:
  - Registered read: rx_data is valid the cycle after an accepted rx_read_en and holds until the next pop.
  - Simultaneous push and pop on a non-empty, non-full FIFO: both take effect, count unchanged.
  - Pointers wrap modulo FIFO_DEPTH; an extra pointer bit distinguishes full from empty.
- clear_status and a set event in the same cycle: set wins.

## Timing
- Reset values: MISO 0, rx_data 8'h00, rx_empty 1, rx_full 0, tx_empty 1, tx_full 0, busy 0, byte_done 0, rx_overrun 0, tx_underrun 0; FSM in IDLE; FIFOs emptied.
- Reset mid-frame aborts the frame. After release the block waits in IDLE for the next CS_n fall; a still-low CS_n is not treated as a new frame.
- Pin-to-edge-detect latency: 3 clk. MISO updates ≤ 4 clk after the SCLK fall (or CS_n fall) reaches the pin.
- Master requirements:
  - SCLK high and low time ≥ 4 clk each.
  - First SCLK rise ≥ 6 clk after CS_n fall.
  - CS_n high time ≥ 4 clk.
- byte_done and the RX push occur 4 clk after the 8th SCLK rise at the pin. RX data is poppable one cycle later.
- Status flags update the cycle after a push or pop.

## Structure
- Package spi_pkg: state enum (IDLE, LOAD, SHIFT) and SPI_WORD_W=8. Shared with the master side.
- Sub-module byte_fifo (parameters DEPTH, WIDTH): synchronous, registered read, full/empty flags; instantiated twice.
- Synchronizers reuse the codebase's existing 2-flop sync module.

## Test plan
- Reset, then one frame: master sends 8'hA5 with TX FIFO preloaded with 8'h3C → RX pops 8'hA5, master reads 8'h3C, one byte_done pulse, no flags.
- 4-byte burst: master sends 8'h00..8'h03, TX preloaded with 8'h10..8'h13 → RX holds 00..03 in order, master reads 10..13, 4 byte_done pulses.
- TX empty: master sends one byte → master reads 8'hFF; tx_underrun=1 until a clear_status pulse; clear issued on the same cycle as a new underrun leaves it 1.
- RX overrun with FIFO_DEPTH=4: 5 bytes sent with no reads → first 4 retained, 5th dropped, rx_overrun=1, rx_full=1.
- CS_n raised after 5 SCLK rises → no push, no byte_done, MISO=0; the next full frame is received correctly.
- rst_n asserted mid-byte → all outputs take their reset values; no spurious frame while CS_n is still low after release.
